// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared definitions for the load/store unit: opcode encodings, the access
// size field carried inside the opcode, FSM states and an opcode legality
// helper.
//
// Opcode layout:
//   [3]   store (1) / load (0)
//   [2]   zero-extend a load (LBU/LHU/LWU); 0 means sign-extend
//   [1:0] log2 of the access size in bytes
// Any encoding not listed in memacc_op_e (including MEMACC_NOP) is
// executed as a no-op.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    MEMACC_LB  = 4'b0000,
    MEMACC_LH  = 4'b0001,
    MEMACC_LW  = 4'b0010,
    MEMACC_LD  = 4'b0011,
    MEMACC_LBU = 4'b0100,
    MEMACC_LHU = 4'b0101,
    MEMACC_LWU = 4'b0110,
    MEMACC_SB  = 4'b1000,
    MEMACC_SH  = 4'b1001,
    MEMACC_SW  = 4'b1010,
    MEMACC_SD  = 4'b1011,
    MEMACC_NOP = 4'b1111
  } memacc_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } memacc_size_e;

  localparam int unsigned OP_STORE_BIT = 3;
  localparam int unsigned OP_ZEXT_BIT  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } memacc_state_e;

  // 64-bit-only ops are legal only when the bus is 64 bits wide.
  function automatic logic memacc_op_known(input logic [3:0] op, input logic wide);
    logic known;
    case (op)
      MEMACC_LB, MEMACC_LBU, MEMACC_LH, MEMACC_LHU,
      MEMACC_LW, MEMACC_SB, MEMACC_SH, MEMACC_SW:   known = 1'b1;
      MEMACC_LWU, MEMACC_LD, MEMACC_SD:             known = wide;
      default:                                      known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
// Combinational byte-lane steering for the load/store unit.
//   lane       in  low address bits (byte offset within the bus word)
//   size       in  access size
//   zext       in  zero-extend (1) or sign-extend (0) load data
//   wdata_src  in  store source register value
//   rdata      in  raw bus read data
//   sel        out byte-lane enables
//   wdata_rep  out store data replicated across the bus word
//   misalign   out offset is not a multiple of the access size
//   load_data  out selected and extended load result
// Lane selection always uses the offset rounded down to the access size, so
// a misaligned offset that is allowed through is silently aligned.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] lane,
  input  memacc_size_e                    size,
  input  logic                            zext,
  input  logic [DATA_WIDTH-1:0]           wdata_src,
  input  logic [DATA_WIDTH-1:0]           rdata,
  output logic [DATA_WIDTH/8-1:0]         sel,
  output logic [DATA_WIDTH-1:0]           wdata_rep,
  output logic                            misalign,
  output logic [DATA_WIDTH-1:0]           load_data
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(SEL_WIDTH);
  localparam int unsigned HALF_REP  = SEL_WIDTH / 2;
  localparam int unsigned WORD_REP  = SEL_WIDTH / 4;

  logic [LANE_BITS-1:0]  size_mask;
  logic [LANE_BITS-1:0]  lane_al;
  logic [DATA_WIDTH-1:0] rd_shift;

  always_comb begin
    size_mask = '0;
    case (size)
      SZ_BYTE: size_mask = '0;
      SZ_HALF: size_mask = LANE_BITS'(1);
      SZ_WORD: size_mask = LANE_BITS'(3);
      default: size_mask = '1;
    endcase
  end

  assign misalign = |(lane & size_mask);
  assign lane_al  = lane & ~size_mask;
  assign rd_shift = rdata >> {lane_al, 3'b000};

  always_comb begin
    sel       = '0;
    wdata_rep = wdata_src;
    case (size)
      SZ_BYTE: begin
        sel       = SEL_WIDTH'(1) << lane_al;
        wdata_rep = {SEL_WIDTH{wdata_src[7:0]}};
      end
      SZ_HALF: begin
        sel       = SEL_WIDTH'(3) << lane_al;
        wdata_rep = {HALF_REP{wdata_src[15:0]}};
      end
      SZ_WORD: begin
        sel       = SEL_WIDTH'(15) << lane_al;
        wdata_rep = {WORD_REP{wdata_src[31:0]}};
      end
      default: begin
        sel       = '1;
        wdata_rep = wdata_src;
      end
    endcase
  end

  always_comb begin
    load_data = rd_shift;
    case (size)
      SZ_BYTE: begin
        if (zext) load_data = DATA_WIDTH'(rd_shift[7:0]);
        else      load_data = DATA_WIDTH'($signed(rd_shift[7:0]));
      end
      SZ_HALF: begin
        if (zext) load_data = DATA_WIDTH'(rd_shift[15:0]);
        else      load_data = DATA_WIDTH'($signed(rd_shift[15:0]));
      end
      SZ_WORD: begin
        if (zext) load_data = DATA_WIDTH'(rd_shift[31:0]);
        else      load_data = DATA_WIDTH'($signed(rd_shift[31:0]));
      end
      default: load_data = rd_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Multi-cycle load/store unit at the EX/MEM boundary. Accepts one op at a
// time, forms the effective address base + sext(imm), runs one req/ack bus
// transfer while stalling the pipeline, then pulses resp_valid with the
// extended load data (0 for stores) in the first IDLE cycle afterwards.
//
// Ports: clk, rst (sync, active-high), flush;
//   request : req_valid/req_ready, req_op, req_base, req_imm, req_wdata
//   pipeline: stall_req
//   bus     : bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_rdata, bus_ack
//   response: resp_valid, resp_data, exc_misalign, exc_bus_err
//
// Build option: define MEMACC_ALIGN_EXC_EN to turn a misaligned access into
// an exc_misalign response with no bus traffic. Without it the address is
// silently aligned down to the access size and exc_misalign stays 0.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_op,
  input  logic [DATA_WIDTH-1:0]         req_base,
  input  logic [15:0]                   req_imm,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  output logic                          stall_req,
  output logic                          bus_req,
  output logic                          bus_we,
  output logic [ADDR_WIDTH-1:0]         bus_addr,
  output logic [DATA_WIDTH/8-1:0]       bus_sel,
  output logic [DATA_WIDTH-1:0]         bus_wdata,
  input  logic [DATA_WIDTH-1:0]         bus_rdata,
  input  logic                          bus_ack,
  output logic                          resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          exc_misalign,
  output logic                          exc_bus_err
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(SEL_WIDTH);
  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          WIDE_BUS  = (DATA_WIDTH == 64);
`ifdef MEMACC_ALIGN_EXC_EN
  localparam bit          ALIGN_EXC = 1'b1;
`else
  localparam bit          ALIGN_EXC = 1'b0;
`endif

  memacc_state_e         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  flushed_q, flushed_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  exc_mis_q, exc_mis_d;
  logic                  exc_bus_q, exc_bus_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LANE_BITS-1:0]  lane_q;
  memacc_size_e          size_q;
  logic                  zext_q;
  logic                  store_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  in_idle, accept, req_known, suppress;
  logic [LANE_BITS-1:0]  al_lane;
  memacc_size_e          al_size;
  logic                  al_zext, al_misalign;
  logic [SEL_WIDTH-1:0]  al_sel;
  logic [DATA_WIDTH-1:0] al_wdata, al_load;

  assign eff_addr  = ADDR_WIDTH'(req_base) + ADDR_WIDTH'($signed(req_imm));
  assign in_idle   = (state_q == ST_IDLE);
  assign accept    = in_idle && req_valid && !flush;
  assign req_known = memacc_op_known(req_op, WIDE_BUS);
  // A flush seen at any point of the transfer (including the ack cycle)
  // cancels the response, not the bus transaction.
  assign suppress  = flushed_q || flush;

  // One steering instance: in IDLE it looks at the incoming request (for the
  // misalign check), in BUS at the captured op.
  assign al_lane = in_idle ? eff_addr[LANE_BITS-1:0] : lane_q;
  assign al_size = in_idle ? memacc_size_e'(req_op[1:0]) : size_q;
  assign al_zext = in_idle ? req_op[OP_ZEXT_BIT] : zext_q;

  mem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .lane      (al_lane),
    .size      (al_size),
    .zext      (al_zext),
    .wdata_src (wdata_q),
    .rdata     (bus_rdata),
    .sel       (al_sel),
    .wdata_rep (al_wdata),
    .misalign  (al_misalign),
    .load_data (al_load)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flushed_d    = flushed_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    exc_mis_d    = 1'b0;
    exc_bus_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!req_known) begin
            resp_valid_d = 1'b1;
          end else if (ALIGN_EXC && al_misalign) begin
            resp_valid_d = 1'b1;
            exc_mis_d    = 1'b1;
          end else begin
            state_d   = ST_BUS;
            cnt_d     = '0;
            flushed_d = 1'b0;
          end
        end
      end
      ST_BUS: begin
        if (flush) flushed_d = 1'b1;
        // Ack is checked first so it wins over a same-cycle timeout.
        if (bus_ack) begin
          state_d      = ST_IDLE;
          resp_valid_d = !suppress;
          resp_data_d  = store_q ? '0 : al_load;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          state_d      = ST_IDLE;
          resp_valid_d = !suppress;
          exc_bus_d    = !suppress;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: reset applies here only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      flushed_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      exc_mis_q    <= 1'b0;
      exc_bus_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flushed_q    <= flushed_d;
      resp_valid_q <= resp_valid_d;
      exc_mis_q    <= exc_mis_d;
      exc_bus_q    <= exc_bus_d;
    end
  end

  // Captured op and response data: unreset, every consumer is gated by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= {eff_addr[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
      lane_q  <= eff_addr[LANE_BITS-1:0];
      size_q  <= memacc_size_e'(req_op[1:0]);
      zext_q  <= req_op[OP_ZEXT_BIT];
      store_q <= req_op[OP_STORE_BIT];
      wdata_q <= req_wdata;
    end
    resp_data_q <= resp_data_d;
  end

  assign req_ready    = in_idle;
  assign bus_req      = (state_q == ST_BUS);
  assign stall_req    = bus_req && !flushed_q;
  assign bus_we       = bus_req && store_q;
  assign bus_addr     = bus_req ? addr_q : '0;
  assign bus_sel      = bus_req ? al_sel : '0;
  assign bus_wdata    = bus_req ? al_wdata : '0;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_valid_q ? resp_data_q : '0;
  assign exc_misalign = exc_mis_q;
  assign exc_bus_err  = exc_bus_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO32 = 4;
  localparam int TO64 = 6;
`ifdef MEMACC_ALIGN_EXC_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, use64, bus_ack;
  logic [3:0]  req_op;
  logic [63:0] req_base, req_wdata, bus_rdata;
  logic [15:0] req_imm;

  logic        r32_ready, s32_stall, b32_req, b32_we, r32_valid, e32_mis, e32_bus;
  logic [31:0] b32_addr, b32_wdata, r32_data;
  logic [3:0]  b32_sel;
  logic        r64_ready, s64_stall, b64_req, b64_we, r64_valid, e64_mis, e64_bus;
  logic [31:0] b64_addr;
  logic [63:0] b64_wdata, r64_data;
  logic [7:0]  b64_sel;

  logic [63:0] o_ready, o_stall, o_req, o_we, o_addr, o_sel, o_wdata, o_rv, o_rdata, o_emis, o_ebus;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid && !use64), .req_ready(r32_ready),
    .req_op(req_op), .req_base(req_base[31:0]), .req_imm(req_imm), .req_wdata(req_wdata[31:0]),
    .stall_req(s32_stall), .bus_req(b32_req), .bus_we(b32_we), .bus_addr(b32_addr),
    .bus_sel(b32_sel), .bus_wdata(b32_wdata), .bus_rdata(bus_rdata[31:0]), .bus_ack(bus_ack && !use64),
    .resp_valid(r32_valid), .resp_data(r32_data), .exc_misalign(e32_mis), .exc_bus_err(e32_bus)
  );

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(TO64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid && use64), .req_ready(r64_ready),
    .req_op(req_op), .req_base(req_base), .req_imm(req_imm), .req_wdata(req_wdata),
    .stall_req(s64_stall), .bus_req(b64_req), .bus_we(b64_we), .bus_addr(b64_addr),
    .bus_sel(b64_sel), .bus_wdata(b64_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack && use64),
    .resp_valid(r64_valid), .resp_data(r64_data), .exc_misalign(e64_mis), .exc_bus_err(e64_bus)
  );

  assign o_ready = use64 ? 64'(r64_ready) : 64'(r32_ready);
  assign o_stall = use64 ? 64'(s64_stall) : 64'(s32_stall);
  assign o_req   = use64 ? 64'(b64_req)   : 64'(b32_req);
  assign o_we    = use64 ? 64'(b64_we)    : 64'(b32_we);
  assign o_addr  = use64 ? 64'(b64_addr)  : 64'(b32_addr);
  assign o_sel   = use64 ? 64'(b64_sel)   : 64'(b32_sel);
  assign o_wdata = use64 ? b64_wdata      : 64'(b32_wdata);
  assign o_rv    = use64 ? 64'(r64_valid) : 64'(r32_valid);
  assign o_rdata = use64 ? r64_data       : 64'(r32_data);
  assign o_emis  = use64 ? 64'(e64_mis)   : 64'(e32_mis);
  assign o_ebus  = use64 ? 64'(e64_bus)   : 64'(e32_bus);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: byte-level view of the access, independent of the RTL structure.
  function automatic void model(input logic wide, input logic [3:0] op, input logic [63:0] base,
                                input logic [15:0] imm, input logic [63:0] wd, input logic [63:0] rd,
                                output bit known, output bit mis, output bit st,
                                output logic [63:0] addr, output logic [63:0] sel,
                                output logic [63:0] wrep, output logic [63:0] ld);
    int nb, sz, off;
    bit sgn, neg;
    logic [63:0] ea;
    nb = wide ? 8 : 4;
    known = 1'b1; st = 1'b0; sgn = 1'b0; sz = 1;
    case (op)
      MEMACC_LB:  begin sz = 1; sgn = 1'b1; end
      MEMACC_LBU: sz = 1;
      MEMACC_LH:  begin sz = 2; sgn = 1'b1; end
      MEMACC_LHU: sz = 2;
      MEMACC_LW:  begin sz = 4; sgn = 1'b1; end
      MEMACC_LWU: begin sz = 4; known = wide; end
      MEMACC_LD:  begin sz = 8; known = wide; end
      MEMACC_SB:  begin sz = 1; st = 1'b1; end
      MEMACC_SH:  begin sz = 2; st = 1'b1; end
      MEMACC_SW:  begin sz = 4; st = 1'b1; end
      MEMACC_SD:  begin sz = 8; st = 1'b1; known = wide; end
      default:    known = 1'b0;
    endcase
    ea   = (base + {{48{imm[15]}}, imm}) & 64'hFFFF_FFFF;
    off  = int'(ea % 64'(nb));
    addr = ea - 64'(off);
    mis  = (off % sz) != 0;
    off  = off - (off % sz);
    sel = '0; wrep = '0; ld = '0;
    neg = sgn && rd[8*(off + sz) - 1];
    for (int i = 0; i < nb; i++) begin
      if (i >= off && i < off + sz) sel[i] = 1'b1;
      wrep[8*i +: 8] = wd[8*(i % sz) +: 8];
      if (i < sz) ld[8*i +: 8] = rd[8*(off + i) +: 8];
      else        ld[8*i +: 8] = neg ? 8'hFF : 8'h00;
    end
  endfunction

  // ack_after: BUS cycles without ack before the ack (-1 = never).
  // flush_at : BUS cycles before flush is pulsed (-1 = none).
  task automatic run_op(input logic wide, input logic [3:0] op, input logic [63:0] base,
                        input logic [15:0] imm, input logic [63:0] wd, input logic [63:0] rd,
                        input int ack_after, input int flush_at);
    bit known, mis, st, acked, timed, flushed;
    logic [63:0] e_addr, e_sel, e_wrep, e_ld;
    int to_lim, n;
    model(wide, op, base, imm, wd, rd, known, mis, st, e_addr, e_sel, e_wrep, e_ld);
    @(negedge clk);
    use64 = wide;
    #1;
    chk("idle_ready", o_ready, 64'd1);
    chk("idle_rv", o_rv, 64'd0);
    req_valid = 1'b1; req_op = op; req_base = base; req_imm = imm; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_op = MEMACC_NOP; req_base = {$urandom, $urandom}; req_imm = 16'($urandom);
    if (!known || (ALIGN && mis)) begin
      chk("nobus_req", o_req, 64'd0);
      chk("nobus_rv", o_rv, 64'd1);
      chk("nobus_data", o_rdata, 64'd0);
      chk("nobus_mis", o_emis, 64'(known && ALIGN && mis));
      chk("nobus_berr", o_ebus, 64'd0);
    end else begin
      to_lim = wide ? TO64 : TO32;
      n = 0; acked = 1'b0; timed = 1'b0; flushed = 1'b0;
      while (!acked && !timed) begin
        n++;
        chk("bus_req", o_req, 64'd1);
        chk("stall", o_stall, 64'(!flushed));
        chk("bus_addr", o_addr, e_addr);
        chk("bus_sel", o_sel, e_sel);
        chk("bus_we", o_we, 64'(st));
        if (st) chk("bus_wdata", o_wdata, e_wrep);
        chk("bus_rv", o_rv, 64'd0);
        if (n - 1 == flush_at) begin flush = 1'b1; flushed = 1'b1; end
        if (n - 1 == ack_after) begin bus_ack = 1'b1; bus_rdata = rd; acked = 1'b1; end
        else if (n == to_lim) timed = 1'b1;
        @(negedge clk);
        flush = 1'b0; bus_ack = 1'b0; bus_rdata = {$urandom, $urandom};
      end
      chk("done_req", o_req, 64'd0);
      chk("done_stall", o_stall, 64'd0);
      chk("done_ready", o_ready, 64'd1);
      chk("resp_valid", o_rv, 64'(!flushed));
      if (!flushed) begin
        chk("resp_data", o_rdata, (acked && !st) ? e_ld : 64'd0);
        chk("resp_berr", o_ebus, 64'(timed));
        chk("resp_mis", o_emis, 64'd0);
      end
      if (timed) begin
        @(negedge clk);
        chk("to_ready_next", o_ready, 64'd1);
        chk("to_rv_once", o_rv, 64'd0);
      end
    end
  endtask

  logic [3:0] op_tab [14] = '{MEMACC_LB, MEMACC_LBU, MEMACC_LH, MEMACC_LHU, MEMACC_LW, MEMACC_LWU,
                              MEMACC_LD, MEMACC_SB, MEMACC_SH, MEMACC_SW, MEMACC_SD, MEMACC_NOP,
                              4'b0111, 4'b1100};

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; use64 = 1'b0; bus_ack = 1'b0;
    req_op = MEMACC_NOP; req_base = '0; req_imm = '0; req_wdata = '0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      use64 = w[0];
      #1;
      chk("rst_ready", o_ready, 64'd1);
      chk("rst_req", o_req, 64'd0);
      chk("rst_stall", o_stall, 64'd0);
      chk("rst_sel", o_sel, 64'd0);
      chk("rst_rv", o_rv, 64'd0);
      chk("rst_data", o_rdata, 64'd0);
      chk("rst_exc", o_emis | o_ebus, 64'd0);
    end

    // Directed cases
    run_op(1'b0, MEMACC_SB,  64'h1000, 16'h0003, 64'hAB, 64'h0, 2, -1);
    run_op(1'b0, MEMACC_LB,  64'h2000, 16'h0001, 64'h0, 64'h0000_8000, 0, -1);
    run_op(1'b0, MEMACC_LBU, 64'h2000, 16'h0001, 64'h0, 64'h0000_8000, 0, -1);
    run_op(1'b0, MEMACC_LH,  64'h2000, 16'h0001, 64'h0, 64'h1234_8765, 1, -1);
    run_op(1'b0, MEMACC_LW,  64'h4000, 16'h0000, 64'h0, 64'h0, -1, -1);
    run_op(1'b0, MEMACC_LW,  64'h5000, 16'h0004, 64'h0, 64'hCAFE_F00D, TO32 - 1, -1);
    run_op(1'b0, MEMACC_SW,  64'h6000, 16'h0008, 64'h1122_3344, 64'h0, 3, 0);
    run_op(1'b0, MEMACC_LD,  64'h0008, 16'h0000, 64'h0, 64'h0, 0, -1);
    run_op(1'b0, MEMACC_LW,  64'h1010, 16'hFFF0, 64'h0, 64'h8000_0000, 0, -1);
    run_op(1'b0, MEMACC_SH,  64'h7000, 16'h0002, 64'hBEEF, 64'h0, 0, -1);
    run_op(1'b1, MEMACC_LD,  64'h0008, 16'h0000, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, -1);
    run_op(1'b1, MEMACC_LWU, 64'h0000, 16'h000C, 64'h0, 64'h8000_0001_1111_2222, 1, -1);
    run_op(1'b1, MEMACC_SH,  64'h0100, 16'h0006, 64'h1234, 64'h0, 0, -1);
    run_op(1'b1, MEMACC_SD,  64'h0200, 16'h0000, 64'h0102_0304_0506_0708, 64'h0, 2, -1);

    // flush in IDLE suppresses the accept
    @(negedge clk);
    use64 = 1'b0;
    req_valid = 1'b1; flush = 1'b1; req_op = MEMACC_SB; req_base = 64'h3000; req_imm = '0;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("iflush_req", o_req, 64'd0);
    chk("iflush_rv", o_rv, 64'd0);
    @(negedge clk);
    chk("iflush_rv2", o_rv, 64'd0);

    // reset in the middle of a transfer, then a late ack in IDLE
    req_valid = 1'b1; req_op = MEMACC_LW; req_base = 64'h3000; req_imm = '0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mrst_busy", o_req, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_req", o_req, 64'd0);
    chk("mrst_ready", o_ready, 64'd1);
    chk("mrst_stall", o_stall, 64'd0);
    bus_ack = 1'b1; bus_rdata = 64'h5555;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("late_ack_rv", o_rv, 64'd0);
    chk("late_ack_req", o_req, 64'd0);
    @(negedge clk);
    chk("late_ack_rv2", o_rv, 64'd0);

    // Randomised ops on both widths
    for (int k = 0; k < 120; k++) begin
      logic [15:0] rimm;
      int fa;
      rimm = 16'($urandom_range(0, 63)) - 16'd32;
      fa   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_op(1'($urandom_range(0, 1)), op_tab[$urandom_range(0, 13)],
             {$urandom, $urandom}, rimm, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 7)) - 1, fa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised, multi-cycle load/store unit for the EX/MEM boundary of the toy CPU.
- Accepts one memory op at a time and computes the effective address as base + sign-extended 16-bit offset.
- Drives a req/ack data bus, holds a pipeline stall while the access is in flight, then returns the extended load data.
- Generalised over data width (32/64) and ack timeout; adds handshaking, a bus-error path and optional misalignment exceptions.

Parameters:
- ADDR_WIDTH, 32, bus address width; effective address is truncated to this width.
- DATA_WIDTH, 32, bus word width; legal values 32 or 64. SEL_WIDTH = DATA_WIDTH/8; LANE_BITS = log2(SEL_WIDTH).
- TIMEOUT_CYCLES, 255, maximum ack-wait cycles before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; aborts the current op
- req_valid  in  1  op offered by EX
- req_ready  out  1  unit can accept an op (state IDLE)
- req_op  in  4  memacc opcode (package encoding)
- req_base  in  DATA_WIDTH  base register value
- req_imm  in  16  instruction offset field
- req_wdata  in  DATA_WIDTH  store source register value
- stall_req  out  1  pipeline stall request
- bus_req  out  1  bus request
- bus_we  out  1  write enable
- bus_addr  out  ADDR_WIDTH  word-aligned address (low LANE_BITS = 0)
- bus_sel  out  SEL_WIDTH  byte lane enables
- bus_wdata  out  DATA_WIDTH  lane-replicated store data
- bus_rdata  in  DATA_WIDTH  read data, valid with bus_ack
- bus_ack  in  1  single-cycle transfer completion
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  DATA_WIDTH  extended load result; 0 for stores
- exc_misalign  out  1  misaligned access exception (1-cycle, with resp_valid)
- exc_bus_err  out  1  timeout exception (1-cycle, with resp_valid)

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready = 1; timeout counter = 0.
- FSM IDLE -> BUS -> IDLE. RESP is not a state: resp_* are registered pulses asserted in the first IDLE cycle after completion.
- IDLE:
  - Handshake on req_valid & req_ready: register op/address/data, enter BUS, assert bus_req and stall_req the next cycle.
  - An unknown opcode is treated as NOP: resp_valid next cycle with data 0, no bus activity.
- BUS:
  - bus_req, bus_we, bus_addr, bus_sel and bus_wdata stay stable until bus_ack.
  - On bus_ack: drop bus_req and stall_req; capture the extracted load data; pulse resp_valid next cycle.
  - Latency: best case 3 cycles from accept to resp_valid (ack in first BUS cycle).
- Lane select:
  - Byte ops: bus_sel = one-hot at lane addr[LANE_BITS-1:0].
  - Half: 2-bit mask at lane addr & ~1. Word: 4-bit mask at addr & ~3.
  - Double (64 only): all ones.
- Store data: source replicated across the word (byte xSEL_WIDTH, half xSEL_WIDTH/2, word xSEL_WIDTH/4).
- Load extract: select the lane, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to DATA_WIDTH.
- 64-bit-only ops (LWU, LD, SD) at DATA_WIDTH=32: treated as unknown (NOP).
- Timeout:
  - Counter increments each BUS cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop bus_req, pulse resp_valid + exc_bus_err, resp_data = 0.
  - Ack in the same cycle as expiry: the ack wins.
- flush:
  - In IDLE: suppresses the accept.
  - In BUS: keeps bus_req until ack (the bus transaction is not cancelled) but suppresses resp_valid; stall_req drops immediately.
- rst mid-transfer: immediate IDLE, bus_req = 0 next cycle; a late ack in IDLE is ignored.
- Simultaneous completion and new req_valid: the new op is accepted only after req_ready returns (no same-cycle reaccept).

Optional Feature:
- Macro: MEMACC_ALIGN_EXC_EN.
- Defined:
  - Address not naturally aligned for the access size -> no bus access.
  - Next cycle: resp_valid + exc_misalign, resp_data = 0.
- Undefined:
  - Low address bits below the access size are forced to 0 (silent alignment).
  - exc_misalign is tied to 0.

Decomposition:
- Shared package (defines include):
  - MEMACC opcode encodings: LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD, NOP.
  - Access-size field and sign-extend flag within the opcode.
  - FSM state encodings.
- Sub-module mem_lane_align (combinational): addr low bits + size -> bus_sel, replicated wdata, misalign flag, load extraction. The FSM stays in the parent.

Test Plan:
- DATA_WIDTH=32:
  - SB base=0x1000, imm=0x0003, wdata=0xAB, ack after 2 cycles -> bus_addr=0x1000, bus_sel=1000, bus_wdata=0xABABABAB; stall_req for 3 cycles; resp_valid once.
  - LB at addr 0x2001, rdata=0x0000_8000 -> resp_data=0xFFFFFF80. Same case with LBU -> 0x00000080.
  - LH at addr 0x2001 with MEMACC_ALIGN_EXC_EN -> no bus_req, exc_misalign=1 next cycle. Without the macro -> bus_sel=0011.
  - Never ack, TIMEOUT_CYCLES=4 -> exc_bus_err with resp_valid after 4 BUS cycles; req_ready=1 the following cycle.
  - flush during BUS, ack 3 cycles later -> no resp_valid; stall_req=0 the cycle after flush.
- DATA_WIDTH=64:
  - LD at 0x8 -> bus_sel=0xFF, resp_data=rdata.
  - LWU at 0xC, rdata upper=0x8000_0001 -> resp_data=0x0000_0000_8000_0001.
